// File: rtl/l1d_cache_pkg.sv
// l1d_cache_pkg
// Shared types and encodings for the L1 data-cache controller:
//   - state_t            : controller FSM states
//   - ADDR_*             : pmem_addr_mux_sel encodings (request tag, tag A, tag B)
//   - DIN_*              : data_in_mux_sel encodings (modified hit line, MDR)
//   - WAY_*              : way identifiers used for the registered victim
//   - victim_addr_sel()  : pmem address select for writing back a given way
package l1d_cache_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WB_LATCH,
        WRITEBACK,
        FILL,
        INSTALL
    } state_t;

    localparam logic [1:0] ADDR_REQ  = 2'd0;
    localparam logic [1:0] ADDR_TAGA = 2'd1;
    localparam logic [1:0] ADDR_TAGB = 2'd2;

    localparam logic DIN_HIT = 1'b0;
    localparam logic DIN_MDR = 1'b1;

    localparam logic WAY_A = 1'b0;
    localparam logic WAY_B = 1'b1;

    // Write-back address comes from the tag of the way being evicted.
    function automatic logic [1:0] victim_addr_sel(input logic victim);
        return (victim == WAY_B) ? ADDR_TAGB : ADDR_TAGA;
    endfunction

endpackage

// File: rtl/l1d_sat_counter.sv
// l1d_sat_counter
// Saturating event counter used for the cache performance counters.
// Ports:
//   clk   - rising-edge clock
//   clr   - synchronous clear (active-high), takes priority over inc
//   inc   - count one event this cycle
//   count - current value, sticks at all-ones
module l1d_sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= sat_inc(count);
        end
    end

endmodule

// File: rtl/l1d_cache_control.sv
// l1d_cache_control
// Control FSM for a 2-way set-associative, write-back L1 data cache.
// Hits complete combinationally in IDLE; misses evict the LRU way (writing
// it back first when dirty), fill from pmem, install, and then return to
// IDLE where the still-pending request hits.
//
// Build option: define L1D_PERF_CNT_EN to enable the hit/miss/write-back
// performance counters; otherwise the counter outputs are tied to 0.
//
// Ports:
//   clk, rst_n                      - clock, synchronous active-low reset
//   mem_read, mem_write, mem_resp   - CPU request / one-cycle completion
//   pmem_read, pmem_write, pmem_resp- memory request (held) / acknowledge
//   hit, hitA, validA_out, validB_out, dirtyA_out, dirtyB_out, lru_out
//                                   - datapath status (lru_out = victim way)
//   data*_W, tag*_W, valid*_W, dirty*_W, dirty*_in
//                                   - per-way array write enables / dirty data
//   lru_in, lru_W                   - LRU update
//   data_in_mux_sel, pmem_addr_mux_sel, load_mdr, load_pmem_data_out
//                                   - datapath steering and register loads
//   hit_count, miss_count, wb_count - performance counters (CNT_W bits)
module l1d_cache_control
    import l1d_cache_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mem_read,
    input  logic             mem_write,
    output logic             mem_resp,
    output logic             pmem_read,
    output logic             pmem_write,
    input  logic             pmem_resp,
    input  logic             hit,
    input  logic             hitA,
    input  logic             validA_out,
    input  logic             validB_out,
    input  logic             dirtyA_out,
    input  logic             dirtyB_out,
    input  logic             lru_out,
    output logic             dataA_W,
    output logic             dataB_W,
    output logic             tagA_W,
    output logic             tagB_W,
    output logic             validA_W,
    output logic             validB_W,
    output logic             dirtyA_W,
    output logic             dirtyB_W,
    output logic             dirtyA_in,
    output logic             dirtyB_in,
    output logic             lru_in,
    output logic             lru_W,
    output logic             data_in_mux_sel,
    output logic [1:0]       pmem_addr_mux_sel,
    output logic             load_mdr,
    output logic             load_pmem_data_out,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count,
    output logic [CNT_W-1:0] wb_count
);

    state_t state, next_state;
    logic   victim;
    logic   req;
    logic   miss_start;
    logic   victim_dirty;

    // A simultaneous read and write is handled as a write.
    assign req = mem_read | mem_write;

    assign victim_dirty = (lru_out == WAY_B) ? (validB_out & dirtyB_out)
                                             : (validA_out & dirtyA_out);

    // The victim is frozen when the miss starts so LRU activity during the
    // miss cannot retarget the write-back or the install.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            victim <= WAY_A;
        end else begin
            state <= next_state;
            if (miss_start) begin
                victim <= lru_out;
            end
        end
    end

    always_comb begin
        next_state         = state;
        miss_start         = 1'b0;
        mem_resp           = 1'b0;
        pmem_read          = 1'b0;
        pmem_write         = 1'b0;
        dataA_W            = 1'b0;
        dataB_W            = 1'b0;
        tagA_W             = 1'b0;
        tagB_W             = 1'b0;
        validA_W           = 1'b0;
        validB_W           = 1'b0;
        dirtyA_W           = 1'b0;
        dirtyB_W           = 1'b0;
        dirtyA_in          = 1'b0;
        dirtyB_in          = 1'b0;
        lru_in             = 1'b0;
        lru_W              = 1'b0;
        data_in_mux_sel    = DIN_HIT;
        pmem_addr_mux_sel  = ADDR_REQ;
        load_mdr           = 1'b0;
        load_pmem_data_out = 1'b0;

        case (state)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        // Point LRU at the way that was not just used.
                        lru_W    = 1'b1;
                        lru_in   = hitA;
                        if (mem_write) begin
                            data_in_mux_sel = DIN_HIT;
                            if (hitA) begin
                                dataA_W   = 1'b1;
                                dirtyA_W  = 1'b1;
                                dirtyA_in = 1'b1;
                            end else begin
                                dataB_W   = 1'b1;
                                dirtyB_W  = 1'b1;
                                dirtyB_in = 1'b1;
                            end
                        end
                    end else begin
                        miss_start = 1'b1;
                        next_state = victim_dirty ? WB_LATCH : FILL;
                    end
                end
            end

            WB_LATCH: begin
                load_pmem_data_out = 1'b1;
                next_state         = WRITEBACK;
            end

            WRITEBACK: begin
                pmem_write        = 1'b1;
                pmem_addr_mux_sel = victim_addr_sel(victim);
                if (pmem_resp) begin
                    next_state = FILL;
                end
            end

            FILL: begin
                pmem_read         = 1'b1;
                pmem_addr_mux_sel = ADDR_REQ;
                load_mdr          = pmem_resp;
                if (pmem_resp) begin
                    next_state = INSTALL;
                end
            end

            INSTALL: begin
                data_in_mux_sel = DIN_MDR;
                if (victim == WAY_B) begin
                    dataB_W  = 1'b1;
                    tagB_W   = 1'b1;
                    validB_W = 1'b1;
                    dirtyB_W = 1'b1;
                end else begin
                    dataA_W  = 1'b1;
                    tagA_W   = 1'b1;
                    validA_W = 1'b1;
                    dirtyA_W = 1'b1;
                end
                next_state = IDLE;
            end

            default: begin
                next_state = IDLE;
            end
        endcase
    end

`ifdef L1D_PERF_CNT_EN
    logic wb_done;
    assign wb_done = (state == WRITEBACK) && pmem_resp;

    l1d_sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .clr   (!rst_n),
        .inc   (mem_resp),
        .count (hit_count)
    );

    l1d_sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .clr   (!rst_n),
        .inc   (miss_start),
        .count (miss_count)
    );

    l1d_sat_counter #(.CNT_W(CNT_W)) u_wb_cnt (
        .clk   (clk),
        .clr   (!rst_n),
        .inc   (wb_done),
        .count (wb_count)
    );
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

endmodule

// File: tb/tb_l1d_cache_control.sv
// tb_l1d_cache_control
// Bench for l1d_cache_control. A small two-way, single-set datapath is
// emulated around the controller (its arrays are updated only by the
// controller's write enables) and a pmem responder acknowledges after a
// programmable number of cycles. Each request is predicted by a
// transaction-level cache model (hit/miss, victim, dirty eviction, latency,
// counters) and the observed behaviour is compared against it.
module tb_l1d_cache_control;

    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;
`ifdef L1D_PERF_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          mem_read, mem_write, mem_resp;
    logic          pmem_read, pmem_write, pmem_resp;
    logic          hit, hitA, validA_out, validB_out, dirtyA_out, dirtyB_out, lru_out;
    logic          dataA_W, dataB_W, tagA_W, tagB_W, validA_W, validB_W;
    logic          dirtyA_W, dirtyB_W, dirtyA_in, dirtyB_in, lru_in, lru_W;
    logic          data_in_mux_sel, load_mdr, load_pmem_data_out;
    logic [1:0]    pmem_addr_mux_sel;
    logic [CW-1:0] hit_count, miss_count, wb_count;

    always #5 clk = ~clk;

    l1d_cache_control #(.CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .hit(hit), .hitA(hitA), .validA_out(validA_out), .validB_out(validB_out),
        .dirtyA_out(dirtyA_out), .dirtyB_out(dirtyB_out), .lru_out(lru_out),
        .dataA_W(dataA_W), .dataB_W(dataB_W), .tagA_W(tagA_W), .tagB_W(tagB_W),
        .validA_W(validA_W), .validB_W(validB_W), .dirtyA_W(dirtyA_W), .dirtyB_W(dirtyB_W),
        .dirtyA_in(dirtyA_in), .dirtyB_in(dirtyB_in), .lru_in(lru_in), .lru_W(lru_W),
        .data_in_mux_sel(data_in_mux_sel), .pmem_addr_mux_sel(pmem_addr_mux_sel),
        .load_mdr(load_mdr), .load_pmem_data_out(load_pmem_data_out),
        .hit_count(hit_count), .miss_count(miss_count), .wb_count(wb_count)
    );

    // Emulated datapath (one set, ways 0=A, 1=B)
    logic [3:0] e_tag [2];
    logic       e_valid [2];
    logic       e_dirty [2];
    logic       e_lru;
    logic [3:0] req_tag;

    assign hitA       = e_valid[0] && (e_tag[0] == req_tag);
    assign hit        = hitA || (e_valid[1] && (e_tag[1] == req_tag));
    assign validA_out = e_valid[0];
    assign validB_out = e_valid[1];
    assign dirtyA_out = e_dirty[0];
    assign dirtyB_out = e_dirty[1];
    assign lru_out    = e_lru;

    logic [19:0] outs;
    logic [7:0]  we8;
    assign outs = {mem_resp, pmem_read, pmem_write, dataA_W, dataB_W, tagA_W, tagB_W,
                   validA_W, validB_W, dirtyA_W, dirtyB_W, dirtyA_in, dirtyB_in,
                   lru_in, lru_W, data_in_mux_sel, pmem_addr_mux_sel, load_mdr,
                   load_pmem_data_out};
    assign we8  = {dataA_W, dataB_W, dirtyA_W, dirtyB_W, tagA_W, tagB_W, validA_W, validB_W};

    // Reference model of the cache set
    logic [3:0] m_tag [2];
    bit         m_valid [2];
    bit         m_dirty [2];
    bit         m_lru;
    int         m_hits, m_miss, m_wb;

    int n_vec = 0;
    int n_err = 0;

    // pmem responder and per-transaction observations
    int         pmem_lat, busy;
    bit         pmem_manual;
    logic [1:0] exp_wsel;
    int         st_resp, st_ld, st_wbhs, st_badsel, st_fill, st_mdr_bad, st_inst;
    logic [7:0] st_inst_we, r_we;
    logic [2:0] st_inst_din;
    logic [1:0] r_din;
    logic       r_dsel, r_lru_w, r_lru_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v > SAT) ? SAT : v;
    endfunction

    function automatic int cexp(input int v);
        return CNT_ON ? v : 0;
    endfunction

    task automatic preload(input bit va, input bit da, input logic [3:0] ta,
                           input bit vb, input bit db, input logic [3:0] tb,
                           input bit lru);
        e_valid[0] = va; e_dirty[0] = da; e_tag[0] = ta;
        e_valid[1] = vb; e_dirty[1] = db; e_tag[1] = tb;
        e_lru = lru;
        m_valid[0] = va; m_dirty[0] = da; m_tag[0] = ta;
        m_valid[1] = vb; m_dirty[1] = db; m_tag[1] = tb;
        m_lru = lru;
    endtask

    // One clock: observe at the falling edge, apply array writes at the
    // rising edge, then drive pmem_resp for the new cycle.
    task automatic tick();
        logic       s_rst, s_dA, s_dB, s_lw, s_li;
        logic [7:0] s_we;
        logic [3:0] s_tag;
        @(negedge clk);
        s_rst = rst_n; s_we = we8; s_dA = dirtyA_in; s_dB = dirtyB_in;
        s_lw = lru_W; s_li = lru_in; s_tag = req_tag;
        if (mem_resp) begin
            st_resp++;
            r_we = we8; r_din = {dirtyA_in, dirtyB_in}; r_dsel = data_in_mux_sel;
            r_lru_w = lru_W; r_lru_in = lru_in;
        end
        if (load_pmem_data_out) st_ld++;
        if (pmem_write && pmem_resp) st_wbhs++;
        if (pmem_write && pmem_addr_mux_sel != exp_wsel) st_badsel++;
        if (pmem_read) begin
            st_fill++;
            if (pmem_addr_mux_sel != 2'd0) st_badsel++;
        end
        if (load_mdr != (pmem_read && pmem_resp)) st_mdr_bad++;
        if (tagA_W || tagB_W) begin
            st_inst++;
            st_inst_we  = we8;
            st_inst_din = {dirtyA_in, dirtyB_in, data_in_mux_sel};
        end
        @(posedge clk);
        if (s_rst) begin
            if (s_we[3]) e_tag[0] = s_tag;
            if (s_we[2]) e_tag[1] = s_tag;
            if (s_we[1]) e_valid[0] = 1'b1;
            if (s_we[0]) e_valid[1] = 1'b1;
            if (s_we[5]) e_dirty[0] = s_dA;
            if (s_we[4]) e_dirty[1] = s_dB;
            if (s_lw)    e_lru = s_li;
        end
        #1;
        if (!pmem_manual) begin
            if (pmem_read || pmem_write) begin
                busy++;
                pmem_resp = (busy >= pmem_lat);
                if (pmem_resp) busy = 0;
            end else begin
                busy = 0;
                pmem_resp = 1'b0;
            end
        end
    endtask

    task automatic check_counters(input string tag);
        check({tag, "_hit_count"},  32'(hit_count),  cexp(m_hits));
        check({tag, "_miss_count"}, 32'(miss_count), cexp(m_miss));
        check({tag, "_wb_count"},   32'(wb_count),   cexp(m_wb));
    endtask

    // op: 0 read, 1 write, 2 read+write (behaves as write)
    task automatic txn(input logic [3:0] tag, input int op, input int lat, input bit drop);
        bit is_hit, dirty, wr, dp;
        int way, v, rway, exp_lat, got_lat, bound;
        wr = (op != 0);
        is_hit = 0; way = 0; dirty = 0;
        for (int w = 0; w < 2; w++)
            if (m_valid[w] && m_tag[w] == tag) begin is_hit = 1; way = w; end
        v  = m_lru ? 1 : 0;
        dp = drop && !is_hit;
        if (is_hit) exp_lat = 0;
        else begin
            dirty   = m_valid[v] && m_dirty[v];
            exp_lat = dirty ? 2 * lat + 3 : lat + 2;
        end
        rway     = is_hit ? way : v;
        exp_wsel = (v == 1) ? 2'd2 : 2'd1;
        st_resp = 0; st_ld = 0; st_wbhs = 0; st_badsel = 0; st_fill = 0;
        st_mdr_bad = 0; st_inst = 0; st_inst_we = '0; st_inst_din = '0;
        r_we = '0; r_din = '0; r_dsel = 1'b0; r_lru_w = 1'b0; r_lru_in = 1'b0;

        pmem_lat  = lat;
        req_tag   = tag;
        mem_read  = (op != 1);
        mem_write = (op != 0);
        got_lat   = -1;
        bound     = dp ? exp_lat + 4 : 3 * lat + 12;
        for (int c = 0; c < bound; c++) begin
            tick();
            if (dp && c == 0) begin mem_read = 1'b0; mem_write = 1'b0; end
            if (st_resp > 0 && got_lat < 0) begin
                got_lat = c;
                if (!dp) break;
            end
        end
        mem_read = 1'b0; mem_write = 1'b0;

        // expected cache effects
        if (is_hit) begin
            m_hits = sat(m_hits + 1);
            m_lru  = (way == 0);
            if (wr) m_dirty[way] = 1;
        end else begin
            m_miss = sat(m_miss + 1);
            if (dirty) m_wb = sat(m_wb + 1);
            m_tag[v] = tag; m_valid[v] = 1; m_dirty[v] = 0;
            if (!dp) begin
                m_hits = sat(m_hits + 1);
                m_lru  = (v == 0);
                if (wr) m_dirty[v] = 1;
            end
        end

        if (dp) begin
            check("resp_after_drop", st_resp, 0);
        end else begin
            check("latency", got_lat, exp_lat);
            check("resp_count", st_resp, 1);
            check("resp_lru", {r_lru_w, r_lru_in}, {1'b1, rway == 0});
            check("resp_we", r_we, !wr ? 8'h00 : (rway == 0 ? 8'hA0 : 8'h50));
            check("resp_dirty_in", r_din, !wr ? 2'b00 : (rway == 0 ? 2'b10 : 2'b01));
            check("resp_dsel", r_dsel, 0);
        end
        check("wb_latch_pulses", st_ld, (!is_hit && dirty) ? 1 : 0);
        check("wb_handshakes", st_wbhs, (!is_hit && dirty) ? 1 : 0);
        check("pmem_addr_sel", st_badsel, 0);
        check("load_mdr", st_mdr_bad, 0);
        if (!is_hit) begin
            check("fill_cycles", st_fill, lat);
            check("install_count", st_inst, 1);
            check("install_we", st_inst_we, (v == 0) ? 8'hAA : 8'h55);
            check("install_din", st_inst_din, 3'b001);
        end
        check("set_state",
              {e_valid[0], e_valid[1], e_dirty[0], e_dirty[1], e_lru,
               e_valid[0] ? e_tag[0] : 4'h0, e_valid[1] ? e_tag[1] : 4'h0},
              {m_valid[0], m_valid[1], m_dirty[0], m_dirty[1], m_lru,
               m_valid[0] ? m_tag[0] : 4'h0, m_valid[1] ? m_tag[1] : 4'h0});
        check_counters("txn");
    endtask

    initial begin
        rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        pmem_manual = 1'b0; busy = 0; pmem_lat = 1; req_tag = 4'h0; exp_wsel = 2'd1;
        m_hits = 0; m_miss = 0; m_wb = 0;
        preload(0, 0, 4'h0, 0, 0, 4'h0, 0);
        repeat (3) tick();
        #1;
        check("reset_outs", outs, 0);
        check_counters("reset");
        rst_n = 1'b1;
        tick();

        // read hit on way B
        preload(0, 0, 4'h0, 1, 0, 4'h5, 0);
        txn(4'h5, 0, 2, 0);
        // write hit on way A
        preload(1, 0, 4'h3, 1, 0, 4'h5, 0);
        txn(4'h3, 1, 2, 0);
        // clean miss, victim B, response on the 4th fill cycle
        txn(4'h9, 0, 4, 0);
        // dirty miss, victim A (tag 3 was written above)
        txn(4'hB, 0, 3, 0);

        // reset while a write-back is outstanding
        preload(1, 1, 4'h1, 0, 0, 4'h0, 0);
        pmem_lat = 50; req_tag = 4'h7; mem_read = 1'b1;
        for (int c = 0; c < 6 && !pmem_write; c++) tick();
        check("wb_active", pmem_write, 1);
        rst_n = 1'b0;
        tick();
        mem_read = 1'b0;
        #1;
        m_hits = 0; m_miss = 0; m_wb = 0;
        check("rst_mid_wb_outs", outs, 0);
        check_counters("rst_mid_wb");
        rst_n = 1'b1; pmem_manual = 1'b1; pmem_resp = 1'b1;
        #1;
        check("stray_resp_outs", outs, 0);
        tick();
        pmem_resp = 1'b0;
        #1;
        check("post_stray_outs", outs, 0);
        pmem_manual = 1'b0; busy = 0;
        preload(0, 0, 4'h0, 0, 0, 4'h0, 0);

        // randomized traffic, including simultaneous read/write, dropped
        // requests and stray pmem acknowledges while idle
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                pmem_manual = 1'b1; pmem_resp = 1'b1;
                #1;
                check("idle_stray_resp", outs, 0);
                tick();
                pmem_resp = 1'b0; pmem_manual = 1'b0; busy = 0;
            end
            txn(4'($urandom_range(0, 5)), int'($urandom_range(0, 2)),
                int'($urandom_range(1, 5)), $urandom_range(0, 7) == 0);
            if ($urandom_range(0, 2) == 0) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
